// File: rtl/pulse_width_meter_if.sv
// Result read channel of the pulse width meter.
//   m_valid   : a record sits at the FIFO head
//   m_ready   : consumer takes the head record this cycle
//   m_width   : pulse width in clock cycles, saturating
//   m_timeout : record was closed by the timeout rather than a trailing edge
// master = meter side, slave = consumer side.
interface pulse_width_meter_if #(
    parameter int CNT_W = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] m_width;
    logic             m_timeout;

    modport master (output m_valid, m_width, m_timeout, input m_ready);
    modport slave  (input m_valid, m_width, m_timeout, output m_ready);
endinterface

// File: rtl/pulse_width_meter.sv
// Pulse width meter: synchronises an asynchronous probe net, detects pulses
// that leave and return to IDLE_LEVEL, measures their width in clock cycles
// and queues {width, timeout} records in a small FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : arms the meter; dropping it aborts a pulse in progress
//   sig_in      : asynchronous probe input
//   timeout     : maximum pulse width in cycles, 0 = no timeout
//   m           : valid/ready result channel (master side)
//   pulse_count : records pushed since reset, wraps
//   overflow    : sticky, a record was dropped on a full FIFO
module pulse_width_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter bit IDLE_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] timeout,
    pulse_width_meter_if.master m,
    output logic [CNT_W-1:0] pulse_count,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [CNT_W-1:0] width;
        logic             to;
    } rec_t;

    typedef enum logic [1:0] {DISARMED, WAIT_IDLE, ARMED, PULSE} state_t;

    // ---------------- input synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end

    assign active = (sync_q[SYNC_STAGES-1] != IDLE_LEVEL);

    // ---------------- measurement FSM ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    rec_t             push_rec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        push_rec = '{width: cnt_q, to: 1'b0};
        if (!enable) begin
            state_d = DISARMED;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DISARMED:  state_d = WAIT_IDLE;
                // Only arm once the net is idle, so a pulse already in
                // flight when enabled is never measured short.
                WAIT_IDLE: if (!active) state_d = ARMED;
                ARMED: begin
                    if (active) begin
                        state_d = PULSE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PULSE: begin
                    // Trailing edge wins over a timeout on the same cycle.
                    if (!active) begin
                        push    = 1'b1;
                        state_d = ARMED;
                    end else if (timeout != '0 && cnt_q == timeout) begin
                        push     = 1'b1;
                        push_rec = '{width: timeout, to: 1'b1};
                        state_d  = WAIT_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    // ---------------- result FIFO ----------------
    rec_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    rec_t          head_q, head_d;
    logic          pop, push_ok, full;

    assign pop     = m.m_valid & m.m_ready;
    assign full    = (count_q == FULL_CNT);
    // A pop on a full FIFO frees the slot the push needs.
    assign push_ok = push & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    // Head register: follows the next entry on a pop, takes the pushed
    // record when it lands in an empty (or emptying) FIFO, holds otherwise.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count_q > 1)  head_d = mem[rd_ptr_q + AW'(1)];
            else if (push_ok) head_d = push_rec;
        end else if (count_q == '0 && push_ok) begin
            head_d = push_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            pulse_count <= '0;
            overflow    <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (push_ok) begin
                wr_ptr_q    <= wr_ptr_q + AW'(1);
                pulse_count <= pulse_count + CNT_W'(1);
            end
            if (pop)               rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !push_ok)  overflow <= 1'b1;
        end
    end

    assign m.m_valid   = (count_q != '0);
    assign m.m_width   = head_q.width;
    assign m.m_timeout = head_q.to;
endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [CNT_W-1:0] width;
        logic             to;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] timeout = '0;
    logic [CNT_W-1:0] pulse_count;
    logic             overflow;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    pulse_width_meter_if #(.CNT_W(CNT_W)) mif();

    pulse_width_meter #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .FIFO_DEPTH(4), .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .timeout(timeout), .m(mif.master),
        .pulse_count(pulse_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake seen mid-cycle is checked against the
    // oldest expected record.
    always @(negedge clk) begin
        if (rst_n && mif.m_valid && mif.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got width=%0d to=%0b want no record",
                         mif.m_width, mif.m_timeout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({mif.m_width, mif.m_timeout} !== {e.width, e.to}) begin
                    failures++;
                    $display("FAIL sb_record got width=%0d to=%0b want width=%0d to=%0b",
                             mif.m_width, mif.m_timeout, e.width, e.to);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pulse(input int w, input int gap);
        sig_in = 1'b1;
        step(w);
        sig_in = 1'b0;
        step(gap);
    endtask

    task automatic drain(output int left);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
        left = exp_q.size();
    endtask

    task automatic do_reset;
        rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0; timeout = '0;
        mif.m_ready = 1'b0;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        mif.m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({mif.m_valid, mif.m_width, mif.m_timeout, pulse_count, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b w=%0d to=%0b pc=%0d ov=%0b want all 0",
                     mif.m_valid, mif.m_width, mif.m_timeout, pulse_count, overflow);
        end
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic;
        enable = 1'b1;
        step(4);
        sig_in = 1'b1;
        step(5);
        sig_in = 1'b0;
        step(2);
        checks++;
        if (mif.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got %0b want 0", mif.m_valid);
        end
        step(1);
        checks++;
        if (mif.m_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency_valid got %0b want 1", mif.m_valid);
        end
        checks++;
        if ({mif.m_width, mif.m_timeout} !== {16'd5, 1'b0}) begin
            failures++;
            $display("FAIL basic_record got w=%0d to=%0b want w=5 to=0", mif.m_width, mif.m_timeout);
        end
        checks++;
        if (pulse_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_count got %0d want 1", pulse_count);
        end
        step(3);
        checks++;
        if (mif.m_width !== 16'd5) begin
            failures++;
            $display("FAIL basic_hold got w=%0d want 5", mif.m_width);
        end
        exp_q.push_back('{width: 16'd5, to: 1'b0});
        mif.m_ready = 1'b1;
        step(3);
    endtask

    task automatic test_arm_mid_pulse;
        int left;
        enable = 1'b0;
        step(2);
        sig_in = 1'b1;
        step(3);
        enable = 1'b1;
        step(7);
        sig_in = 1'b0;
        step(6);
        checks++;
        if (pulse_count !== 16'd1 || mif.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL armmid_no_record got pc=%0d v=%0b want pc=1 v=0", pulse_count, mif.m_valid);
        end
        exp_q.push_back('{width: 16'd3, to: 1'b0});
        drive_pulse(3, 6);
        drain(left);
        checks++;
        if (left != 0 || pulse_count !== 16'd2) begin
            failures++;
            $display("FAIL armmid_follow got left=%0d pc=%0d want left=0 pc=2", left, pulse_count);
        end
    endtask

    task automatic test_timeout;
        int left;
        timeout = 16'd8;
        exp_q.push_back('{width: 16'd8, to: 1'b1});
        sig_in = 1'b1;
        step(20);
        checks++;
        if (pulse_count !== 16'd3) begin
            failures++;
            $display("FAIL timeout_single got pc=%0d want 3", pulse_count);
        end
        sig_in = 1'b0;
        step(6);
        checks++;
        if (pulse_count !== 16'd3) begin
            failures++;
            $display("FAIL timeout_no_trailing got pc=%0d want 3", pulse_count);
        end
        exp_q.push_back('{width: 16'd4, to: 1'b0});
        drive_pulse(4, 6);
        drain(left);
        checks++;
        if (left != 0 || pulse_count !== 16'd4) begin
            failures++;
            $display("FAIL timeout_next got left=%0d pc=%0d want left=0 pc=4", left, pulse_count);
        end
        timeout = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        enable = 1'b1;
        step(4);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back('{width: 16'd2, to: 1'b0});
            drive_pulse(2, 4);
        end
        checks++;
        if (overflow !== 1'b1 || pulse_count !== 16'd4) begin
            failures++;
            $display("FAIL bp_overflow got ov=%0b pc=%0d want ov=1 pc=4", overflow, pulse_count);
        end
        checks++;
        if (mif.m_valid !== 1'b1 || mif.m_width !== 16'd2) begin
            failures++;
            $display("FAIL bp_head got v=%0b w=%0d want v=1 w=2", mif.m_valid, mif.m_width);
        end
        mif.m_ready = 1'b1;
        step(3);
        checks++;
        if (mif.m_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid_after3 got %0b want 1", mif.m_valid);
        end
        step(1);
        checks++;
        if (mif.m_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_empty_after4 got v=%0b left=%0d want v=0 left=0", mif.m_valid, exp_q.size());
        end
    endtask

    task automatic test_full_pop;
        int left;
        do_reset();
        enable = 1'b1;
        step(4);
        for (int w = 1; w <= 4; w++) begin
            exp_q.push_back('{width: CNT_W'(w), to: 1'b0});
            drive_pulse(w, 5);
        end
        exp_q.push_back('{width: 16'd6, to: 1'b0});
        sig_in = 1'b1;
        step(6);
        sig_in = 1'b0;
        step(2);
        mif.m_ready = 1'b1;   // pop lands on the push edge
        step(1);
        checks++;
        if (overflow !== 1'b0 || pulse_count !== 16'd5) begin
            failures++;
            $display("FAIL fullpop_push got ov=%0b pc=%0d want ov=0 pc=5", overflow, pulse_count);
        end
        drain(left);
        checks++;
        if (left != 0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_drain got left=%0d ov=%0b want left=0 ov=0", left, overflow);
        end
    endtask

    task automatic test_abort;
        int left;
        mif.m_ready = 1'b1;
        sig_in = 1'b1;
        step(3);
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(3);
        sig_in = 1'b0;
        step(6);
        checks++;
        if (pulse_count !== 16'd5 || mif.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_record got pc=%0d v=%0b want pc=5 v=0", pulse_count, mif.m_valid);
        end
        exp_q.push_back('{width: 16'd2, to: 1'b0});
        drive_pulse(2, 6);
        drain(left);
        checks++;
        if (left != 0 || pulse_count !== 16'd6) begin
            failures++;
            $display("FAIL abort_recover got left=%0d pc=%0d want left=0 pc=6", left, pulse_count);
        end
        // Leave one record unread, then reset in the middle of another pulse.
        mif.m_ready = 1'b0;
        drive_pulse(3, 6);
        checks++;
        if (mif.m_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got v=%0b want 1", mif.m_valid);
        end
        sig_in = 1'b1;
        step(4);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mif.m_valid, mif.m_width, mif.m_timeout, pulse_count, overflow} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got v=%0b w=%0d to=%0b pc=%0d ov=%0b want all 0",
                     mif.m_valid, mif.m_width, mif.m_timeout, pulse_count, overflow);
        end
        sig_in = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        mif.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_arm_mid_pulse();
        test_timeout();
        test_backpressure();
        test_full_pop();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Receive-side counterpart to the glitch-injection stimulus used in propagation-delay characterisation. Samples an asynchronous probe net, such as an adder sum bit, and detects pulses that leave and return to the idle level. Measures each pulse width in clock cycles and queues the results.
- Results go into a small FIFO with a valid/ready read interface. A host or bench drains the FIFO to find the narrowest pulse that survived the logic under test.

Parameters:
- CNT_W, 16, width of the pulse-width counter, the timeout, and the pulse counter.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser; minimum 2.
- FIFO_DEPTH, 4, number of records held; must be a power of two, minimum 2.
- IDLE_LEVEL, 0, the level of sig_in between pulses.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arms the meter; deasserting it aborts any pulse in progress.
- sig_in  in  1  asynchronous probe input.
- timeout  in  CNT_W  maximum pulse width in cycles; 0 disables the timeout.
- m_valid  out  1  a record is available at the FIFO head.
- m_ready  in  1  consumer accepts the head record.
- m_width  out  CNT_W  pulse width in cycles, saturating at all-ones.
- m_timeout  out  1  the record was closed by timeout, not by a trailing edge.
- pulse_count  out  CNT_W  number of records pushed since reset; wraps.
- overflow  out  1  sticky flag; a record was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Synchroniser flops load IDLE_LEVEL.
  - FSM goes to DISARMED; width counter = 0; FIFO is emptied.
  - m_valid=0, m_width=0, m_timeout=0, pulse_count=0, overflow=0.
- Input path: s = sig_in after SYNC_STAGES flops. Input-to-s latency is SYNC_STAGES cycles. The FSM uses only s.
- FSM states:
  - DISARMED: go to WAIT_IDLE when enable=1.
  - WAIT_IDLE: go to ARMED on the first cycle that s==IDLE_LEVEL. This rejects a pulse already in progress when the meter is armed.
  - ARMED: on s!=IDLE_LEVEL, go to PULSE and load the counter with 1.
  - PULSE:
    - While s!=IDLE_LEVEL, the counter increments, saturating at 2^CNT_W-1.
    - On s==IDLE_LEVEL, push {width=counter, timeout=0} and return to ARMED.
    - If timeout!=0 and the counter equals timeout while s is still non-idle, push {width=timeout, timeout=1} and go to WAIT_IDLE.
  - From any non-DISARMED state, enable=0 goes to DISARMED the next cycle. A pulse in progress is discarded without a push.
- Width definition: the number of cycles s was non-idle. A 1-cycle-wide s pulse gives m_width=1.
- Push timing: the record is written on the edge where the trailing edge or timeout is detected. m_valid is visible the following cycle. Total latency from the sig_in trailing edge to m_valid = SYNC_STAGES+1 cycles.
- pulse_count increments on every successful push; it does not increment on dropped records.
- FIFO behaviour:
  - Registered outputs; m_width and m_timeout always show the head entry and hold stable while m_valid=1 and m_ready=0.
  - A pop occurs on m_valid&m_ready.
  - Simultaneous push and pop when full: the pop frees a slot, the push succeeds, and overflow is not set.
  - Push when full with no pop: the record is dropped and overflow=1 until reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - When empty: m_valid=0, and m_width/m_timeout hold their last value.
- Pulses narrower than one clock period may be missed. Reporting 0 is prohibited: every reported width is ≥1.
- Reset asserted mid-pulse or mid-handshake: everything clears immediately, and m_valid drops asynchronously.

Test Plan:
- Reset → enable=1, sig_in=0 → drive sig_in=1 for 5 cycles, then 0 → after SYNC_STAGES+1 cycles m_valid=1, m_width=5, m_timeout=0, pulse_count=1.
- Arm mid-pulse: sig_in=1 before enable rises, held for 10 cycles, then 0 → no record. A following 3-cycle pulse → m_width=3.
- Timeout: timeout=8, sig_in=1 for 20 cycles → one record with m_width=8, m_timeout=1. No further record until sig_in returns low and a new pulse occurs.
- Backpressure: m_ready=0, six 2-cycle pulses → four records with m_width=2, overflow=1, pulse_count=4. Drain them → m_valid falls after 4 pops.
- Full with simultaneous pop: FIFO full, m_ready=1 on the push cycle → overflow stays 0 and pulse_count increments.
- Abort: enable=0 for 1 cycle during a pulse → no record. Separately, rst_n=0 mid-pulse → all outputs return to their reset values.
